// File: rtl/step_clock_gen.sv
// step_clock_gen: Bpm-driven 16th-note Step/Beat/Bar pulse generator gated by Play; optional Swing input via STEP_CLOCK_SWING_EN
module step_clock_gen #(
  parameter int CLK_HZ = 50_000_000,
  parameter int ACC_W = 30
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic       Play,
  input  logic [7:0] Bpm,
`ifdef STEP_CLOCK_SWING_EN
  input  logic [2:0] Swing,
`endif
  output logic       Step,
  output logic [3:0] Step_index,
  output logic       Beat,
  output logic       Bar,
  output logic       Running
);
  localparam logic [ACC_W:0] T = (ACC_W+1)'(CLK_HZ * 15);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic play_m_q, play_s_q, play_d_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic step_q, step_d, beat_q, beat_d, bar_q, bar_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] bpm_c;
  logic [ACC_W:0] t_cur, sum;
  logic start, run, hit;
`ifdef STEP_CLOCK_SWING_EN
  localparam logic [ACC_W:0] T8 = (ACC_W+1)'(CLK_HZ * 15 / 8);
  logic [2:0] swing_q, swing_d;
  always_comb begin
    t_cur = idx_q[0] ? T8 * (ACC_W+1)'(4'd8 - {1'b0, swing_q}) : T8 * (ACC_W+1)'(4'd8 + {1'b0, swing_q});
    swing_d = step_d ? Swing : swing_q;
  end
  always_ff @(posedge Clock or negedge nReset)
    if (!nReset) swing_q <= '0;
    else swing_q <= swing_d;
`else
  assign t_cur = T;
`endif
  always_comb begin
    bpm_c = Bpm < 8'd40 ? 8'd40 : Bpm > 8'd240 ? 8'd240 : Bpm;
    sum = {1'b0, acc_q} + (ACC_W+1)'(bpm_c);
    start = play_s_q & ~play_d_q;
    run = state_q == RUN && play_s_q;
    hit = run && sum >= t_cur;
    state_d = (state_q == IDLE ? start : play_s_q) ? RUN : IDLE;
    acc_d = run ? ACC_W'(hit ? sum - t_cur : sum) : '0;
    step_d = state_q == IDLE ? start : hit;
    idx_d = state_q == IDLE && start ? 4'd0 : hit ? idx_q + 4'd1 : idx_q;
    beat_d = step_d && idx_d[1:0] == 2'd0;
    bar_d = step_d && idx_d == 4'd0;
  end
  always_ff @(posedge Clock or negedge nReset)
    if (!nReset) begin
      play_m_q <= 1'b0;
      play_s_q <= 1'b0;
      play_d_q <= 1'b0;
      state_q <= IDLE;
      acc_q <= '0;
      step_q <= 1'b0;
      idx_q <= '0;
      beat_q <= 1'b0;
      bar_q <= 1'b0;
    end else begin
      play_m_q <= Play;
      play_s_q <= play_m_q;
      play_d_q <= play_s_q;
      state_q <= state_d;
      acc_q <= acc_d;
      step_q <= step_d;
      idx_q <= idx_d;
      beat_q <= beat_d;
      bar_q <= bar_d;
    end
  assign Step = step_q;
  assign Step_index = idx_q;
  assign Beat = beat_q;
  assign Bar = bar_q;
  assign Running = play_s_q;
endmodule
